seg7_scan_mux: RTL and testbench



---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_scan_mux.sv | 224 ++++++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the multiplexed 7-segment display path.
//   SEG_BLANK    : segment pattern for an unlit digit (segments are active-low)
//   DP_OFF       : decimal-point level for an unlit point (active-low)
//   scan_state_t : scanner control states (IDLE, SCAN)
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       DP_OFF    = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage : seg7_pkg

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Hex nibble to 7-segment pattern, active-low.
// Bit order of seg is {g, f, e, d, c, b, a}.
// Ports:
//   nibble : in  4  hex value 0..F
//   seg    : out 7  segment drive, 0 = segment lit
// ----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode

// File: rtl/seg7_scan_mux.sv
// ----------------------------------------------------------------------------
// seg7_scan_mux
// N-digit multiplexed 7-segment scanner with refresh prescaler, registered
// outputs, one dead (all-dark) cycle at the start of each digit slot, per-digit
// decimal-point / blanking masks and frame-coherent input snapshots.
//
// Optional build macro: SEG7_SCAN_MUX_LZB_EN
//   defined   -> leading-zero blanking (computed once per frame at snapshot)
//   undefined -> every nibble is displayed, including leading zeros
//
// Ports:
//   clk        : in  1             system clock
//   reset_n    : in  1             asynchronous active-low reset
//   enable     : in  1             scan enable, low forces idle/dark
//   digitals   : in  4*NUM_DIGITS  hex nibbles, digit 0 in bits [3:0]
//   dp_mask    : in  NUM_DIGITS    1 = light decimal point of digit i
//   blank_mask : in  NUM_DIGITS    1 = digit i fully dark
//   oSEG       : out 7             segments, active-low
//   oSEGDP     : out 1             decimal point, active-low
//   oCOM       : out NUM_DIGITS    digit commons, one-hot, active-high
//   frame_tick : out 1             one-cycle pulse at the start of each frame
// ----------------------------------------------------------------------------
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS  = 4,
    parameter  int REFRESH_DIV = 1000,
    localparam int CNT_W       = $clog2(REFRESH_DIV),
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digitals,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              oSEG,
    output logic                    oSEGDP,
    output logic [NUM_DIGITS-1:0]   oCOM,
    output logic                    frame_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    snap_en;

    logic [4*NUM_DIGITS-1:0] snap_dig_reg;
    logic [NUM_DIGITS-1:0]   snap_dp_reg;
    logic [NUM_DIGITS-1:0]   snap_blank_reg;

    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   com_reg, com_next;
    logic                    frame_tick_reg;

    logic [3:0]              nib_arr [NUM_DIGITS];
    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
    logic                    blank_eff;
    logic                    lit;

    // ------------------------------------------------------------------
    // Control FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        snap_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (enable) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    // First cycle of digit 0 is the frame boundary.
                    snap_en = (cnt_reg == '0) && (idx_reg == '0);
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = '0;
                        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame snapshot: inputs are sampled once per frame so a producer
    // updating mid-frame never shows a torn value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_dig_reg   <= '0;
            snap_dp_reg    <= '0;
            snap_blank_reg <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= snap_en;
            if (snap_en) begin
                snap_dig_reg   <= digitals;
                snap_dp_reg    <= dp_mask;
                snap_blank_reg <= blank_mask;
            end
        end
    end

`ifdef SEG7_SCAN_MUX_LZB_EN
    // Leading zeros from the MSB down are suppressed; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
        input logic [4*NUM_DIGITS-1:0] dig
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  run;
        mask = '0;
        run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (run && (dig[4*i +: 4] == 4'h0)) begin
                mask[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        return mask;
    endfunction

    logic [NUM_DIGITS-1:0] snap_lzb_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_lzb_reg <= '0;
        end else if (snap_en) begin
            snap_lzb_reg <= lead_zero_mask(digitals);
        end
    end

    assign blank_eff = snap_blank_reg[idx_reg] | snap_lzb_reg[idx_reg];
`else
    assign blank_eff = snap_blank_reg[idx_reg];
`endif

    // ------------------------------------------------------------------
    // Digit mux and decode
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib_arr[gi] = snap_dig_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_nibble = nib_arr[idx_reg];

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // cnt_reg == 0 is the dead cycle between digits, which guarantees oCOM
    // passes through zero on every digit change. Dropping enable darkens the
    // outputs on the same edge the FSM returns to IDLE.
    assign lit = (state_reg == SCAN) && enable && (cnt_reg != '0);

    always_comb begin
        com_next = '0;
        seg_next = SEG_BLANK;
        dp_next  = DP_OFF;
        if (lit) begin
            com_next = NUM_DIGITS'(1) << idx_reg;
            if (!blank_eff) begin
                seg_next = dec_seg;
                dp_next  = ~snap_dp_reg[idx_reg];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_reg <= SEG_BLANK;
            dp_reg  <= DP_OFF;
            com_reg <= '0;
        end else begin
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            com_reg <= com_next;
        end
    end

    assign oSEG       = seg_reg;
    assign oSEGDP     = dp_reg;
    assign oCOM       = com_reg;
    assign frame_tick = frame_tick_reg;

endmodule : seg7_scan_mux

// File: tb/tb_seg7_scan_mux.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_mux
// Self-checking bench for seg7_scan_mux with NUM_DIGITS=4, REFRESH_DIV=4.
// Expected per-cycle outputs are pushed to a scoreboard queue when a frame's
// stimulus is committed and popped/compared on each falling clock edge.
// ----------------------------------------------------------------------------
module tb_seg7_scan_mux;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int FRAME = ND * DIV;

    logic            clk;
    logic            reset_n;
    logic            enable;
    logic [4*ND-1:0] digitals;
    logic [ND-1:0]   dp_mask;
    logic [ND-1:0]   blank_mask;
    logic [6:0]      oSEG;
    logic            oSEGDP;
    logic [ND-1:0]   oCOM;
    logic            frame_tick;

    seg7_scan_mux #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .digitals   (digitals),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .oSEG       (oSEG),
        .oSEGDP     (oSEGDP),
        .oCOM       (oCOM),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector table: inputs plus hand-derived per-digit expected segments
    // ({d3,d2,d1,d0}) and expected active-low DP levels.
    typedef struct {
        logic [15:0]      dig;
        logic [3:0]       dp;
        logic [3:0]       blank;
        logic [3:0][6:0]  seg;
        logic [3:0]       dpo;
    } vec_t;

    typedef struct {
        logic [3:0] com;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    vec_t vecs [7];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, req);
        end
    endtask

    task automatic apply_inputs(input int v);
        digitals   = vecs[v].dig;
        dp_mask    = vecs[v].dp;
        blank_mask = vecs[v].blank;
    endtask

    task automatic push_dark();
        exp_t e;
        e.com = '0; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input int v, input int ncyc);
        exp_t e;
        int slot, ph;
        for (int c = 0; c < ncyc; c++) begin
            slot = c / DIV;
            ph   = c % DIV;
            e.tick = (c == 0);
            if (ph == 0) begin
                e.com = '0; e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
                e.com = 4'(1 << slot);
                e.seg = vecs[v].seg[slot];
                e.dp  = vecs[v].dpo[slot];
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic check_cycle(input string tag);
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty cycle %0d", tag, cyc);
        end else begin
            e = sb_q.pop_front();
            cmp({tag, " oCOM"},       32'(oCOM),       32'(e.com));
            cmp({tag, " oSEG"},       32'(oSEG),       32'(e.seg));
            cmp({tag, " oSEGDP"},     32'(oSEGDP),     32'(e.dp));
            cmp({tag, " frame_tick"}, 32'(frame_tick), 32'(e.tick));
        end
    endtask

    // Checks ncyc cycles of a frame for vector v; optionally loads vector
    // nxt during digit 1's slot to prove the current frame is unaffected.
    task automatic run_frame(input int v, input int ncyc, input int nxt);
        push_frame(v, ncyc);
        for (int c = 0; c < ncyc; c++) begin
            check_cycle($sformatf("vec%0d c%0d", v, c));
            if (c == 5 && nxt >= 0) apply_inputs(nxt);
        end
        $display("frame vec %0d cycles %0d checks %0d errors %0d", v, ncyc, checks, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
        vecs[2] = '{16'h5678, 4'b0100, 4'b0001, {7'h12, 7'h02, 7'h78, 7'h7F}, 4'b1011};
`ifdef SEG7_SCAN_MUX_LZB_EN
        vecs[3] = '{16'h0040, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
`else
        vecs[3] = '{16'h0040, 4'b0000, 4'b0000, {7'h40, 7'h40, 7'h19, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
`endif
        vecs[5] = '{16'h9EF0, 4'b1111, 4'b0000, {7'h10, 7'h06, 7'h0E, 7'h40}, 4'b0000};
        vecs[6] = '{16'h0800, 4'b1111, 4'b1010, {7'h7F, 7'h00, 7'h7F, 7'h40}, 4'b1010};

        reset_n    = 1'b0;
        enable     = 1'b0;
        digitals   = '0;
        dp_mask    = '0;
        blank_mask = '0;
        repeat (3) @(negedge clk);

        cmp("reset oSEG",       32'(oSEG),       32'h7F);
        cmp("reset oSEGDP",     32'(oSEGDP),     32'h1);
        cmp("reset oCOM",       32'(oCOM),       32'h0);
        cmp("reset frame_tick", 32'(frame_tick), 32'h0);

        // Release reset and enable: one IDLE->SCAN cycle, then frames.
        apply_inputs(0);
        enable  = 1'b1;
        reset_n = 1'b1;
        push_dark();
        check_cycle("start idle");

        for (int v = 0; v < 7; v++) begin
            run_frame(v, FRAME, (v < 6) ? v + 1 : 0);
        end

        // Enable dropped for one edge mid-slot: dark, then restart at digit 0
        // with a fresh snapshot (vector 1 loaded while disabled).
        run_frame(0, 7, -1);
        enable = 1'b0;
        apply_inputs(1);
        push_dark();
        check_cycle("enable low");
        enable = 1'b1;
        push_dark();
        check_cycle("re-enable idle");
        run_frame(1, 8, -1);

        // Asynchronous reset during a lit cycle, well before the next edge.
        #2;
        reset_n = 1'b0;
        #1;
        cmp("async rst oCOM",       32'(oCOM),       32'h0);
        cmp("async rst oSEG",       32'(oSEG),       32'h7F);
        cmp("async rst oSEGDP",     32'(oSEGDP),     32'h1);
        cmp("async rst frame_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        apply_inputs(2);
        reset_n = 1'b1;
        push_dark();
        check_cycle("post-reset idle");
        run_frame(2, FRAME, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg7_scan_mux
